// File: rtl/mem_stage_pkg.sv
// Shared pipeline configuration: register widths, memory op codes,
// access sizes and MEM-stage state encodings, plus small op decoders.
package mem_stage_pkg;

   localparam int RegLen     = 32;
   localparam int RegAddrLen = 5;
   localparam logic [RegLen-1:0] ZERO_WORD = 32'h0000_0000;

   localparam int MemOpLen = 4;
   localparam logic [MemOpLen-1:0] MEM_NONE = 4'd0;
   localparam logic [MemOpLen-1:0] MEM_LB   = 4'd1;
   localparam logic [MemOpLen-1:0] MEM_LH   = 4'd2;
   localparam logic [MemOpLen-1:0] MEM_LW   = 4'd3;
   localparam logic [MemOpLen-1:0] MEM_LBU  = 4'd4;
   localparam logic [MemOpLen-1:0] MEM_LHU  = 4'd5;
   localparam logic [MemOpLen-1:0] MEM_SB   = 4'd6;
   localparam logic [MemOpLen-1:0] MEM_SH   = 4'd7;
   localparam logic [MemOpLen-1:0] MEM_SW   = 4'd8;

   localparam logic [1:0] MemSizeByte = 2'd0;
   localparam logic [1:0] MemSizeHalf = 2'd1;
   localparam logic [1:0] MemSizeWord = 2'd2;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

   // True for any load or store; unknown codes behave like MEM_NONE.
   function automatic logic mem_op_is_mem(input logic [MemOpLen-1:0] op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
         MEM_SB, MEM_SH, MEM_SW: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic mem_op_is_store(input logic [MemOpLen-1:0] op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] mem_op_size(input logic [MemOpLen-1:0] op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return MemSizeByte;
         MEM_LH, MEM_LHU, MEM_SH: return MemSizeHalf;
         MEM_LW, MEM_SW:          return MemSizeWord;
         default:                 return MemSizeByte;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data formatter: turns LSB-aligned raw memory data into the
// register value for the given load op. Purely combinational.
module mem_stage_load_extend
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [MemOpLen-1:0] op,
   input  logic [DATA_W-1:0]   raw,
   output logic [DATA_W-1:0]   data
);

   // Sign/zero extension selected by the load op; words pass through.
   always_comb begin
      data = raw;
      case (op)
         MEM_LB:  data = {{(DATA_W-8){raw[7]}}, raw[7:0]};
         MEM_LH:  data = {{(DATA_W-16){raw[15]}}, raw[15:0]};
         MEM_LBU: data = {{(DATA_W-8){1'b0}}, raw[7:0]};
         MEM_LHU: data = {{(DATA_W-16){1'b0}}, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: ALU results pass straight through; loads/stores issue one
// request to mem_ctrl and stall the pipeline until it completes.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic [DATA_W-1:0]     ex_rd_data,
   input  logic [4:0]            ex_rd_addr,
   input  logic                  ex_rd_enable,
   input  logic [MemOpLen-1:0]   ex_mem_op,
   input  logic [ADDR_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_store_data,
   output logic                  mc_req,
   output logic                  mc_we,
   output logic [ADDR_W-1:0]     mc_addr,
   output logic [1:0]            mc_size,
   output logic [DATA_W-1:0]     mc_wdata,
   input  logic                  mc_done,
   input  logic [DATA_W-1:0]     mc_rdata,
   output logic [DATA_W-1:0]     mem_rd_data,
   output logic [4:0]            mem_rd_addr,
   output logic                  mem_rd_enable,
   output logic                  stall_req
);

   mem_state_e           state_r;
   mem_state_e           state_s;
   logic [MemOpLen-1:0]  op_r;
   logic [DATA_W-1:0]    load_data_r;
   logic [DATA_W-1:0]    ext_data_s;
   logic                 mc_req_r;
   logic                 mc_we_r;
   logic [ADDR_W-1:0]    mc_addr_r;
   logic [1:0]           mc_size_r;
   logic [DATA_W-1:0]    mc_wdata_r;

   // Format the raw read data using the op captured at issue time.
   mem_stage_load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .op   (op_r),
      .raw  (mc_rdata),
      .data (ext_data_s)
   );

   // State, request and load-data registers; frozen while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= MEM_IDLE;
         op_r        <= MEM_NONE;
         load_data_r <= {DATA_W{1'b0}};
         mc_req_r    <= 1'b0;
         mc_we_r     <= 1'b0;
         mc_addr_r   <= {ADDR_W{1'b0}};
         mc_size_r   <= 2'd0;
         mc_wdata_r  <= {DATA_W{1'b0}};
      end else if (rdy) begin
         state_r <= state_s;
         case (state_r)
            MEM_IDLE: begin
               if (mem_op_is_mem(ex_mem_op)) begin
                  op_r       <= ex_mem_op;
                  mc_req_r   <= 1'b1;
                  mc_we_r    <= mem_op_is_store(ex_mem_op);
                  mc_addr_r  <= ex_mem_addr;
                  mc_size_r  <= mem_op_size(ex_mem_op);
                  mc_wdata_r <= ex_store_data;
               end
            end
            MEM_WAIT: begin
               if (mc_done) begin
                  mc_req_r <= 1'b0;
                  mc_we_r  <= 1'b0;
                  // Stores never capture read data.
                  if (!mem_op_is_store(op_r)) begin
                     load_data_r <= ext_data_s;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic; DONE always returns to IDLE as upstream advances.
   always_comb begin
      state_s = state_r;
      case (state_r)
         MEM_IDLE: begin
            if (mem_op_is_mem(ex_mem_op)) begin
               state_s = MEM_WAIT;
            end else begin
               state_s = MEM_IDLE;
            end
         end
         MEM_WAIT: begin
            if (mc_done) begin
               state_s = MEM_DONE;
            end else begin
               state_s = MEM_WAIT;
            end
         end
         MEM_DONE: state_s = MEM_IDLE;
         default:  state_s = MEM_IDLE;
      endcase
   end

   // Writeback/forwarding outputs and stall request; all zero in reset.
   always_comb begin
      mem_rd_data   = ZERO_WORD[DATA_W-1:0];
      mem_rd_addr   = 5'd0;
      mem_rd_enable = 1'b0;
      stall_req     = 1'b0;
      if (rst) begin
         stall_req = 1'b0;
      end else begin
         case (state_r)
            MEM_IDLE: begin
               if (mem_op_is_mem(ex_mem_op)) begin
                  stall_req = 1'b1;
               end else begin
                  mem_rd_data   = ex_rd_data;
                  mem_rd_addr   = ex_rd_addr;
                  mem_rd_enable = ex_rd_enable;
               end
            end
            MEM_WAIT: stall_req = 1'b1;
            MEM_DONE: begin
               mem_rd_addr = ex_rd_addr;
               if (mem_op_is_store(op_r)) begin
                  mem_rd_enable = 1'b0;
               end else begin
                  mem_rd_data   = load_data_r;
                  mem_rd_enable = ex_rd_enable;
               end
            end
            default: stall_req = 1'b0;
         endcase
      end
   end

   assign mc_req   = mc_req_r;
   assign mc_we    = mc_we_r;
   assign mc_addr  = mc_addr_r;
   assign mc_size  = mc_size_r;
   assign mc_wdata = mc_wdata_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [31:0] ex_rd_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_enable;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr, ex_store_data;
   logic        mc_req, mc_we, mc_done;
   logic [31:0] mc_addr, mc_wdata, mc_rdata;
   logic [1:0]  mc_size;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_enable, stall_req;

   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
      .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
      .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_size(mc_size),
      .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
      .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
      .mem_rd_enable(mem_rd_enable), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_ext(input logic [3:0] op, input logic [31:0] r);
      int v;
      if (op == MEM_LB) begin
         v = int'(r & 32'h0000_00FF);
         if (v >= 128) v = v - 256;
         return 32'(v);
      end else if (op == MEM_LH) begin
         v = int'(r & 32'h0000_FFFF);
         if (v >= 32768) v = v - 65536;
         return 32'(v);
      end else if (op == MEM_LBU) begin
         return r & 32'h0000_00FF;
      end else if (op == MEM_LHU) begin
         return r & 32'h0000_FFFF;
      end else begin
         return r;
      end
   endfunction

   function automatic bit ref_is_mem(input logic [3:0] op);
      return (op >= MEM_LB) && (op <= MEM_SW);
   endfunction

   function automatic bit ref_is_store(input logic [3:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic [1:0] ref_size(input logic [3:0] op);
      if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 2'd0;
      else if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2'd1;
      else return 2'd2;
   endfunction

   // Transaction state: a request outstanding at mem_ctrl, or a result
   // being handed to writeback this cycle.
   bit          m_inflight = 1'b0;
   bit          m_retire   = 1'b0;
   logic [3:0]  m_op       = 4'd0;
   logic [31:0] m_ret_data = 32'd0;
   logic        m_mc_req   = 1'b0;
   logic        m_mc_we    = 1'b0;
   logic [31:0] m_mc_addr  = 32'd0;
   logic [1:0]  m_mc_size  = 2'd0;
   logic [31:0] m_mc_wdata = 32'd0;

   // Model advance on each clock edge.
   always @(posedge clk) begin
      if (rst) begin
         m_inflight <= 1'b0; m_retire <= 1'b0;
         m_mc_req <= 1'b0; m_mc_we <= 1'b0; m_mc_addr <= 32'd0;
         m_mc_size <= 2'd0; m_mc_wdata <= 32'd0;
      end else if (rdy) begin
         if (m_retire) begin
            m_retire <= 1'b0;
         end else if (m_inflight) begin
            if (mc_done) begin
               m_inflight <= 1'b0;
               m_retire   <= 1'b1;
               m_mc_req   <= 1'b0;
               m_mc_we    <= 1'b0;
               if (!ref_is_store(m_op)) m_ret_data <= ref_ext(m_op, mc_rdata);
            end
         end else if (ref_is_mem(ex_mem_op)) begin
            m_inflight <= 1'b1;
            m_op       <= ex_mem_op;
            m_mc_req   <= 1'b1;
            m_mc_we    <= ref_is_store(ex_mem_op);
            m_mc_addr  <= ex_mem_addr;
            m_mc_size  <= ref_size(ex_mem_op);
            m_mc_wdata <= ex_store_data;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_data", mem_rd_data, 32'd0);
         chk("rst_addr", {27'd0, mem_rd_addr}, 32'd0);
         chk("rst_en", {31'd0, mem_rd_enable}, 32'd0);
         chk("rst_stall", {31'd0, stall_req}, 32'd0);
      end else if (m_retire) begin
         chk("ret_stall", {31'd0, stall_req}, 32'd0);
         chk("ret_addr", {27'd0, mem_rd_addr}, {27'd0, ex_rd_addr});
         if (ref_is_store(m_op)) begin
            chk("ret_st_en", {31'd0, mem_rd_enable}, 32'd0);
            chk("ret_st_data", mem_rd_data, 32'd0);
         end else begin
            chk("ret_ld_en", {31'd0, mem_rd_enable}, {31'd0, ex_rd_enable});
            chk("ret_ld_data", mem_rd_data, m_ret_data);
         end
      end else if (m_inflight || ref_is_mem(ex_mem_op)) begin
         chk("busy_stall", {31'd0, stall_req}, 32'd1);
         chk("busy_en", {31'd0, mem_rd_enable}, 32'd0);
      end else begin
         chk("pass_stall", {31'd0, stall_req}, 32'd0);
         chk("pass_data", mem_rd_data, ex_rd_data);
         chk("pass_addr", {27'd0, mem_rd_addr}, {27'd0, ex_rd_addr});
         chk("pass_en", {31'd0, mem_rd_enable}, {31'd0, ex_rd_enable});
      end
      chk("mc_req", {31'd0, mc_req}, {31'd0, m_mc_req});
      chk("mc_we", {31'd0, mc_we}, {31'd0, m_mc_we});
      chk("mc_addr", mc_addr, m_mc_addr);
      chk("mc_size", {30'd0, mc_size}, {30'd0, m_mc_size});
      chk("mc_wdata", mc_wdata, m_mc_wdata);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One memory transaction with literal expectations on the result.
   task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input logic [31:0] exp_data,
                          input logic exp_en, input logic [1:0] exp_size,
                          input logic exp_we);
      ex_mem_op = op; ex_mem_addr = addr; ex_store_data = wdata;
      ex_rd_addr = 5'd9; ex_rd_enable = 1'b1; ex_rd_data = 32'hAAAA_5555;
      @(negedge clk);
      chk("txn_issue_stall", {31'd0, stall_req}, 32'd1);
      chk("txn_issue_en", {31'd0, mem_rd_enable}, 32'd0);
      step();
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk("txn_wait_req", {31'd0, mc_req}, 32'd1);
         chk("txn_wait_stall", {31'd0, stall_req}, 32'd1);
         step();
      end
      mc_done = 1'b1; mc_rdata = rdata;
      @(negedge clk);
      chk("txn_req", {31'd0, mc_req}, 32'd1);
      chk("txn_we", {31'd0, mc_we}, {31'd0, exp_we});
      chk("txn_addr", mc_addr, addr);
      chk("txn_size", {30'd0, mc_size}, {30'd0, exp_size});
      chk("txn_wdata", mc_wdata, wdata);
      step();
      mc_done = 1'b0; mc_rdata = 32'h1357_9BDF;
      @(negedge clk);
      chk("txn_done_data", mem_rd_data, exp_data);
      chk("txn_done_en", {31'd0, mem_rd_enable}, {31'd0, exp_en});
      chk("txn_done_addr", {27'd0, mem_rd_addr}, 32'd9);
      chk("txn_done_stall", {31'd0, stall_req}, 32'd0);
      chk("txn_done_req", {31'd0, mc_req}, 32'd0);
      step();
      ex_mem_op = MEM_NONE; ex_rd_data = 32'h0000_0055; ex_rd_addr = 5'd3;
      @(negedge clk);
      chk("txn_back_idle", mem_rd_data, 32'h0000_0055);
      chk("txn_back_stall", {31'd0, stall_req}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1;
      ex_rd_data = 32'hFFFF_FFFF; ex_rd_addr = 5'd31; ex_rd_enable = 1'b1;
      ex_mem_op = MEM_NONE; ex_mem_addr = 32'd0; ex_store_data = 32'd0;
      mc_done = 1'b0; mc_rdata = 32'd0;
      step(); step();
      @(negedge clk);
      chk("reset_out_zero", mem_rd_data, 32'd0);
      chk("reset_req", {31'd0, mc_req}, 32'd0);
      step();
      rst = 1'b0;

      // ALU pass-through
      ex_rd_data = 32'h0000_1234; ex_rd_addr = 5'd5; ex_rd_enable = 1'b1;
      @(negedge clk);
      chk("alu_data", mem_rd_data, 32'h0000_1234);
      chk("alu_addr", {27'd0, mem_rd_addr}, 32'd5);
      chk("alu_en", {31'd0, mem_rd_enable}, 32'd1);
      chk("alu_stall", {31'd0, stall_req}, 32'd0);
      step();

      mem_txn(MEM_LB,  32'h0000_0100, 32'h0, 32'h0000_0080, 3, 32'hFFFF_FF80, 1'b1, 2'd0, 1'b0);
      mem_txn(MEM_LHU, 32'h0000_0104, 32'h0, 32'hABCD_8001, 0, 32'h0000_8001, 1'b1, 2'd1, 1'b0);
      mem_txn(MEM_LW,  32'h0000_0108, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0);
      mem_txn(MEM_LH,  32'h0000_010A, 32'h0, 32'h0000_9000, 0, 32'hFFFF_9000, 1'b1, 2'd1, 1'b0);
      mem_txn(MEM_SH,  32'h0000_0200, 32'h1122_3344, 32'hCAFE_BABE, 2, 32'h0, 1'b0, 2'd1, 1'b1);

      // rdy gating: done pulses while frozen are ignored
      ex_mem_op = MEM_LW; ex_mem_addr = 32'h0000_0300; ex_rd_addr = 5'd4;
      step();
      rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h0BAD_F00D;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         chk("rdy_hold_req", {31'd0, mc_req}, 32'd1);
         chk("rdy_hold_stall", {31'd0, stall_req}, 32'd1);
      end
      rdy = 1'b1;
      step();
      mc_done = 1'b0;
      @(negedge clk);
      chk("rdy_done_data", mem_rd_data, 32'h0BAD_F00D);
      chk("rdy_done_stall", {31'd0, stall_req}, 32'd0);
      step();
      ex_mem_op = MEM_NONE; ex_rd_data = 32'h0000_0066;
      @(negedge clk);
      chk("rdy_once_req", {31'd0, mc_req}, 32'd0);
      chk("rdy_once_data", mem_rd_data, 32'h0000_0066);
      step();

      // Reset in the middle of a store wait
      ex_mem_op = MEM_SW; ex_mem_addr = 32'h0000_0040; ex_store_data = 32'h0000_0099;
      step();
      @(negedge clk);
      chk("rstw_req_before", {31'd0, mc_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw_stall_comb", {31'd0, stall_req}, 32'd0);
      step();
      rst = 1'b0; ex_mem_op = MEM_NONE; ex_rd_data = 32'h0000_0077; mc_done = 1'b1;
      @(negedge clk);
      chk("rstw_req_after", {31'd0, mc_req}, 32'd0);
      chk("rstw_stall_after", {31'd0, stall_req}, 32'd0);
      chk("rstw_pass", mem_rd_data, 32'h0000_0077);
      step();
      mc_done = 1'b0;
      @(negedge clk);
      chk("rstw_stray_done", {31'd0, mc_req}, 32'd0);
      step();

      // Randomized traffic checked by the model
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 99) == 0);
         rdy           = ($urandom_range(0, 9) != 0);
         ex_mem_op     = $urandom_range(0, 1) ? MEM_NONE : 4'($urandom_range(1, 8));
         ex_rd_data    = $urandom;
         ex_rd_addr    = 5'($urandom_range(0, 31));
         ex_rd_enable  = 1'($urandom_range(0, 1));
         ex_mem_addr   = $urandom;
         ex_store_data = $urandom;
         mc_done       = ($urandom_range(0, 2) == 0);
         mc_rdata      = $urandom;
         step();
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between ex_mem and mem_wb.
- Non-memory instructions pass straight through to mem_wb with zero added latency.
- Loads and stores are issued as single requests to mem_ctrl, and the pipeline is stalled until mem_ctrl completes.
- Load data is sign- or zero-extended per funct3 before it goes to mem_wb. The mem_rd_* outputs also feed the ID forwarding path.

Parameters:
- ADDR_W, 32, width of the effective address sent to mem_ctrl
- DATA_W, 32, register and data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, all state is frozen
- ex_rd_data  in  DATA_W  ALU result (non-memory ops)
- ex_rd_addr  in  5  destination register
- ex_rd_enable  in  1  writeback enable
- ex_mem_op  in  4  memory op code (MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW)
- ex_mem_addr  in  ADDR_W  effective address
- ex_store_data  in  DATA_W  rs2 value for stores
- mc_req  out  1  request to mem_ctrl, registered
- mc_we  out  1  1 = store
- mc_addr  out  ADDR_W  request address
- mc_size  out  2  0 = byte, 1 = half, 2 = word
- mc_wdata  out  DATA_W  store data, low bytes significant
- mc_done  in  1  one-cycle completion pulse from mem_ctrl
- mc_rdata  in  DATA_W  raw load data, LSB-aligned, valid with mc_done
- mem_rd_data  out  DATA_W  to mem_wb and forwarding
- mem_rd_addr  out  5  to mem_wb
- mem_rd_enable  out  1  to mem_wb
- stall_req  out  1  stall request to pipeline control

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset → IDLE, mc_req=0, mc_we=0, mc_addr=0, mc_size=0, mc_wdata=0, latched load data=0.
- Combinational outputs are zero on any cycle where rst is high.
- Updates happen only on posedge clk with rdy=1. With rdy=0 the state and all registers hold.
- IDLE, ex_mem_op=MEM_NONE:
  - mem_rd_data/addr/enable = ex_rd_data/addr/enable.
  - stall_req=0.
- IDLE, memory op:
  - stall_req=1 combinationally; mem_rd_enable=0.
  - Next edge: register mc_req=1, mc_we, mc_addr=ex_mem_addr, mc_size from op, mc_wdata=ex_store_data; go to WAIT.
- WAIT:
  - mc_req and its request fields are held stable; stall_req=1; mem_rd_enable=0.
  - On the edge where mc_done=1: mc_req←0, mc_we←0, latch the formatted load data, go to DONE.
- DONE:
  - stall_req=0; mem_rd_addr=ex_rd_addr.
  - Load: mem_rd_data = latched formatted data; mem_rd_enable = ex_rd_enable.
  - Store: mem_rd_enable=0, mem_rd_data=0.
  - Next edge: return to IDLE unconditionally, because the upstream register advances on that same edge. A back-to-back memory op is therefore seen in IDLE the following cycle.
- Load formatting:
  - LB: sign-extend mc_rdata[7:0].
  - LH: sign-extend mc_rdata[15:0].
  - LBU, LHU: zero-extend.
  - LW: pass through.
- mc_done outside WAIT is ignored. A store's mc_rdata is never latched.
- Minimum load/store latency: op arrives cycle 0, mc_req high in cycle 1, mc_done earliest in cycle 1, result visible in DONE in cycle 2. Stall is asserted in cycles 0–1.
- Reset during WAIT: mc_req drops on that edge and the FSM goes to IDLE. mem_ctrl must abandon the request when it sees reset.
- Address alignment is not checked; mem_ctrl is responsible for it.

Decomposition:
- Shared config package, alongside the existing RegLen/RegAddrLen/ZERO_WORD defines, holds:
  - MemOpLen
  - MEM_NONE..MEM_SW codes
  - MemSizeByte/Half/Word
  - state encodings MEM_IDLE/WAIT/DONE
- One natural sub-module, load_extend: purely combinational op + raw data → formatted 32-bit value. It is reused by the mem_wb forwarding checks.

Test Plan:
- ALU pass-through: ex_mem_op=MEM_NONE, ex_rd_data=0x1234, rd=5, en=1 → same cycle mem_rd_data=0x1234, addr=5, enable=1, stall_req=0, mc_req never rises.
- LB sign extension: LB at 0x100, mc_done after 3 WAIT cycles with mc_rdata=0x00000080 → stall_req high throughout; in DONE mem_rd_data=0xFFFFFF80, enable=1; IDLE on the next cycle.
- LHU/LW: LHU with rdata=0xABCD8001 → 0x00008001. LW with rdata=0xDEADBEEF → 0xDEADBEEF.
- SH store: SH addr=0x200, ex_store_data=0x11223344 → mc_req=1, we=1, size=1, wdata=0x11223344 held until mc_done; in DONE mem_rd_enable=0.
- rdy gating: deassert rdy during WAIT while mc_done pulses → no state change. Re-raise rdy with mc_done → DONE is reached exactly once.
- Reset mid-WAIT: rst=1 while mc_req=1 → next edge mc_req=0, state IDLE, stall_req=0. A stray mc_done afterwards is ignored.
